// File: rtl/seq_pattern_ctrl_pkg.sv
// Shared encodings for the word-level "1001" pattern controller and its serial detector.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_e;

  localparam logic [3:0] PATTERN = 4'b1001;

endpackage

// File: rtl/seq_pattern_ctrl_if.sv
// Word handshake and result bundle between a word-oriented client and seq_pattern_ctrl.
interface seq_pattern_ctrl_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_chain;
  logic              in_ready;
  logic              out_valid;
  logic [CNT_W-1:0]  hit_count;
  logic [WORD_W-1:0] hit_mask;
  logic              busy;

  modport master (
    output in_valid, in_data, in_chain,
    input  in_ready, out_valid, hit_count, hit_mask, busy
  );

  modport slave (
    input  in_valid, in_data, in_chain,
    output in_ready, out_valid, hit_count, hit_mask, busy
  );
endinterface

// File: rtl/seq_pattern_ctrl_det.sv
// Serial Moore "1001" detector; S4 exit behaviour selected by SEQ_CTRL_OVERLAP_EN
// (defined: overlapping matches, undefined: non-overlapping matches).
module moore_1001_det
  import seq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic x,
  output logic y
);

  det_state_e ps_q;
  det_state_e ps_d;

  // Detector state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q <= S0;
    end else begin
      ps_q <= ps_d;
    end
  end

  // Next-state logic; clear wins over enable, state holds when idle
  always_comb begin
    ps_d = ps_q;
    if (clr) begin
      ps_d = S0;
    end else if (en) begin
      case (ps_q)
        S0: ps_d = x ? S1 : S0;
        S1: ps_d = x ? S1 : S2;
        S2: ps_d = x ? S1 : S3;
        S3: ps_d = x ? S4 : S0;
`ifdef SEQ_CTRL_OVERLAP_EN
        S4: ps_d = x ? S1 : S2;
`else
        S4: ps_d = x ? S1 : S0;
`endif
        default: ps_d = S0;
      endcase
    end else begin
      ps_d = ps_q;
    end
  end

  assign y = (ps_q == S4);

endmodule

// File: rtl/seq_pattern_ctrl.sv
// Word controller: serializes accepted words MSB-first into moore_1001_det and reports
// per-word hit count and hit-position mask. SEQ_CTRL_OVERLAP_EN selects overlapping detection.
module seq_pattern_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_pattern_ctrl_if.slave  bus
);

  localparam int                IDX_W    = $clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [WORD_W:0]   HIT_TOP  = {1'b1, {WORD_W{1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  ctrl_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic              det_en_s;
  logic              det_clr_s;
  logic              det_x_s;
  logic              det_y_s;
  logic [WORD_W-1:0] hit_bit_s;

  // y lags its completing bit by one cycle, so at index k the hit belongs to bit WORD_W-k
  assign hit_bit_s = WORD_W'(HIT_TOP >> idx_q);

  moore_1001_det u_det (
    .clk (clk),
    .rst (rst),
    .en  (det_en_s),
    .clr (det_clr_s),
    .x   (det_x_s),
    .y   (det_y_s)
  );

  // Controller, bit sequencing and result accumulation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    det_en_s    = 1'b0;
    det_clr_s   = 1'b0;
    det_x_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d    = bus.in_data;
          det_clr_s = ~bus.in_chain;
          idx_d     = {IDX_W{1'b0}};
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        det_en_s = 1'b1;
        det_x_s  = data_q[WORD_W-1];
        data_d   = data_q << 1;
        idx_d    = idx_q + IDX_W'(1);
        // First SHIFT cycle: y still reflects the previous word, so start fresh instead
        if (idx_q == {IDX_W{1'b0}}) begin
          cnt_d  = {CNT_W{1'b0}};
          mask_d = {WORD_W{1'b0}};
        end else if (det_y_s) begin
          mask_d = mask_q | hit_bit_s;
          cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cnt_d  = cnt_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DRAIN: begin
        if (det_y_s) begin
          mask_d = mask_q | hit_bit_s;
          cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cnt_d  = cnt_q;
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Controller and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      data_q      <= {WORD_W{1'b0}};
      mask_q      <= {WORD_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.hit_count = cnt_q;
  assign bus.hit_mask  = mask_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Self-checking bench for seq_pattern_ctrl: directed and random words against a bit-stream window model.
module tb_seq_pattern_ctrl;
  import seq_ctrl_pkg::*;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;
`ifdef SEQ_CTRL_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_pattern_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  bit hist[$];
  int last_end;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    last_end = -100;
  endtask

  // Matches are windows of the stream (since the last clear) equal to PATTERN;
  // without overlap a window may not share bits with the previous counted match.
  task automatic model_word(input logic [7:0] d, input bit chain,
                            output int cnt, output logic [7:0] mask);
    int n;
    logic [3:0] w;
    if (!chain) model_clear();
    cnt  = 0;
    mask = 8'h00;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      hist.push_back(d[i]);
      n = hist.size();
      if (n >= 4) begin
        w = {hist[n-4], hist[n-3], hist[n-2], hist[n-1]};
        if (w == PATTERN && (OVL || ((n - 1) - last_end) >= 4)) begin
          cnt = (cnt < 15) ? cnt + 1 : 15;
          mask[i] = 1'b1;
          last_end = n - 1;
        end
      end
    end
  endtask

  task automatic offer(input logic [7:0] d, input bit chain);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_chain = chain;
    check("ready_c0", bus.in_ready, 32'd1);
    @(posedge clk);
  endtask

  task automatic follow(input int from_k, input int ecnt, input logic [7:0] emask);
    for (int k = from_k; k <= 11; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (k <= 10) begin
        check("ready_busy", bus.in_ready, 32'd0);
        check("busy", bus.busy, 32'd1);
        check("out_valid", bus.out_valid, (k == 10) ? 32'd1 : 32'd0);
      end else begin
        check("ready_idle", bus.in_ready, 32'd1);
        check("busy_idle", bus.busy, 32'd0);
        check("out_valid_idle", bus.out_valid, 32'd0);
      end
      if (k >= 10) begin
        check("hit_count", bus.hit_count, ecnt);
        check("hit_mask", bus.hit_mask, emask);
      end
    end
  endtask

  task automatic run_word(input logic [7:0] d, input bit chain);
    int ec;
    logic [7:0] em;
    model_word(d, chain, ec, em);
    offer(d, chain);
    follow(1, ec, em);
  endtask

  initial begin
    int ca, cb;
    logic [7:0] ma, mb;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_chain = 1'b0;
    model_clear();

    repeat (2) @(negedge clk);
    check("rst_ready", bus.in_ready, 32'd1);
    check("rst_out_valid", bus.out_valid, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_count", bus.hit_count, 32'd0);
    check("rst_mask", bus.hit_mask, 32'd0);
    rst = 1'b1;

    // Directed words
    run_word(8'b1001_0000, 1'b0);
    run_word(8'b1001_0010, 1'b0);
    run_word(8'h99, 1'b0);
    run_word(8'hFF, 1'b0);
    run_word(8'b0000_0100, 1'b0);
    run_word(8'b1000_0000, 1'b1);
    run_word(8'b0000_0100, 1'b0);
    run_word(8'b1000_0000, 1'b0);

    // Back-to-back with in_valid held high and junk offered while busy
    model_word(8'h99, 1'b0, ca, ma);
    offer(8'h99, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("b2b_ready", bus.in_ready, 32'd0);
      check("b2b_busy", bus.busy, 32'd1);
      check("b2b_out_valid", bus.out_valid, (k == 10) ? 32'd1 : 32'd0);
      bus.in_data  = 8'($urandom);
      bus.in_chain = 1'($urandom);
      if (k == 10) begin
        check("b2b_count_a", bus.hit_count, ca);
        check("b2b_mask_a", bus.hit_mask, ma);
        bus.in_data  = 8'b1001_0010;
        bus.in_chain = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_ready_c11", bus.in_ready, 32'd1);
    model_word(8'b1001_0010, 1'b0, cb, mb);
    @(posedge clk);
    follow(1, cb, mb);

    // Reset asserted mid-word
    offer(8'b1001_0000, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("pre_rst_busy", bus.busy, 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", bus.in_ready, 32'd1);
    check("mid_rst_busy", bus.busy, 32'd0);
    check("mid_rst_out_valid", bus.out_valid, 32'd0);
    check("mid_rst_count", bus.hit_count, 32'd0);
    check("mid_rst_mask", bus.hit_mask, 32'd0);
    model_clear();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rst = 1'b1;
      check("post_rst_no_out_valid", bus.out_valid, 32'd0);
    end
    run_word(8'b1001_0000, 1'b1);

    // Randomized words with random chaining
    for (int n = 0; n < 24; n++) begin
      run_word(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
